// File: rtl/legv8_pkg.sv
// Shared types for the LEGv8 memory arbiter: FSM states, transaction owner, watchdog width.
package legv8_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  localparam int TIMEOUT_DEF = 16;
  localparam int WDOG_W      = $clog2(TIMEOUT_DEF) + 1;

  function automatic int wdog_w(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/legv8_arb_pick.sv
// Combinational winner select between the fetch and load/store ports.
// LEGV8_ARB_RR_EN selects round-robin; otherwise D has fixed priority over IF.
module legv8_arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic last_d,
  output logic gnt_if,
  output logic gnt_d
);

`ifdef LEGV8_ARB_RR_EN
  // On conflict, D wins only if IF was granted last
  assign gnt_d = d_req && (!if_req || !last_d);
`else
  logic unused_last_d;
  assign unused_last_d = last_d;
  assign gnt_d = d_req;
`endif

  assign gnt_if = if_req && !gnt_d;

endmodule

// File: rtl/legv8_mem_arbiter.sv
// Shares one single-port memory between LEGv8 fetch (IF) and load/store (D), one transaction in flight.
// Latency: load/fetch 3 cycles, store 2 cycles minimum; watchdog aborts a stuck read. Macro: LEGV8_ARB_RR_EN.
module legv8_mem_arbiter
  import legv8_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              restart_cpu,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int CW = (wdog_w(TIMEOUT) > WDOG_W) ? wdog_w(TIMEOUT) : WDOG_W;

  arb_state_t        state, state_nxt;
  arb_owner_t        own;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CW-1:0]     wcnt;
  logic              last_d;
  logic              pick_if, pick_d;
  logic              grant, timeout_hit, finish;

  legv8_arb_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .last_d (last_d),
    .gnt_if (pick_if),
    .gnt_d  (pick_d)
  );

  assign grant       = (state == IDLE) && !restart_cpu && (if_req || d_req);
  assign if_gnt      = grant && pick_if;
  assign d_gnt       = grant && pick_d;
  assign timeout_hit = (wcnt == CW'(TIMEOUT - 1));
  assign finish      = (state == WAIT) && (mem_rvalid || timeout_hit);

  assign mem_req   = (state == ISSUE);
  assign mem_we    = mem_req && cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  always_ff @(posedge clk) begin
    if (restart_cpu) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (mem_ready) state_nxt = cmd_we ? IDLE : WAIT;
      WAIT:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart_cpu) begin
      own       <= OWN_IF;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      wcnt      <= '0;
      last_d    <= 1'b0;
      if_rvalid <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      if (grant) begin
        own       <= pick_d ? OWN_D : OWN_IF;
        cmd_we    <= pick_d && d_we;
        cmd_addr  <= pick_d ? d_addr : if_addr;
        cmd_wdata <= d_wdata;
        last_d    <= pick_d;
      end
      if (state == ISSUE && mem_ready) begin
        wcnt <= '0;
        if (cmd_we) d_done <= 1'b1;
      end
      // A watchdog abort completes the read with zero data plus err
      if (finish) begin
        err <= !mem_rvalid;
        if (own == OWN_D) begin
          d_done  <= 1'b1;
          d_rdata <= mem_rvalid ? mem_rdata : '0;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rvalid ? mem_rdata : '0;
        end
      end else if (state == WAIT) begin
        wcnt <= wcnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
// Directed-vector bench for legv8_mem_arbiter; expected values are hand-computed per scenario.
module tb_legv8_mem_arbiter;

  logic        clk = 1'b0;
  logic        restart_cpu;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic        d_gnt, d_done;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  legv8_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk), .restart_cpu(restart_cpu),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, outputs sampled at 2ns
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic exp_d [4];

  initial begin
    restart_cpu = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    settle();
    check_vec("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check_vec("rst_pulses", {60'd0, if_rvalid, d_done, err, if_gnt}, 64'd0);
    check_vec("rst_rdata", if_rdata | d_rdata, 64'd0);
    restart_cpu = 1'b0;

    // 1: lone fetch
    step();
    if_req = 1'b1; if_addr = 64'h40; mem_ready = 1'b1;
    settle();
    check_vec("t1_if_gnt", {63'd0, if_gnt}, 64'd1);
    step(); if_req = 1'b0; settle();
    check_vec("t1_mem_req", {63'd0, mem_req}, 64'd1);
    check_vec("t1_mem_addr", mem_addr, 64'h40);
    check_vec("t1_mem_we", {63'd0, mem_we}, 64'd0);
    step(); mem_rvalid = 1'b1; mem_rdata = 64'hD503201F; settle();
    check_vec("t1_rvalid_early", {63'd0, if_rvalid}, 64'd0);
    step(); mem_rvalid = 1'b0; settle();
    check_vec("t1_rvalid", {63'd0, if_rvalid}, 64'd1);
    check_vec("t1_rdata", if_rdata, 64'hD503201F);
    step(); settle();
    check_vec("t1_rvalid_pulse", {63'd0, if_rvalid}, 64'd0);

    // 2: store with mem_ready delayed 3 cycles
    mem_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hAA;
    settle();
    check_vec("t2_d_gnt", {63'd0, d_gnt}, 64'd1);
    step(); d_req = 1'b0; settle();
    check_vec("t2_mem_wdata", mem_wdata, 64'hAA);
    check_vec("t2_mem_addr", mem_addr, 64'h100);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      settle();
      check_vec($sformatf("t2_mem_req_%0d", k), {62'd0, mem_req, mem_we}, 64'd3);
      check_vec($sformatf("t2_no_done_%0d", k), {63'd0, d_done}, 64'd0);
      step();
    end
    mem_ready = 1'b0; settle();
    check_vec("t2_req_drop", {63'd0, mem_req}, 64'd0);
    check_vec("t2_d_done", {63'd0, d_done}, 64'd1);
    step(); settle();
    check_vec("t2_done_pulse", {63'd0, d_done}, 64'd0);

    // 3: simultaneous requests, pointer starts at IF-last after reset
    restart_cpu = 1'b1; step(); restart_cpu = 1'b0;
`ifdef LEGV8_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h55;
    d_we = 1'b0; d_addr = 64'h200; if_addr = 64'h80;
    if_req = 1'b1; d_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      settle();
      check_vec($sformatf("t3_round%0d", r), {62'd0, d_gnt, if_gnt}, {62'd0, exp_d[r], !exp_d[r]});
      step();
      if (r == 3) begin if_req = 1'b0; d_req = 1'b0; end
      step(); step();
    end
    settle();
    check_vec("t3_last_done", {62'd0, d_done, if_rvalid}, {62'd0, exp_d[3], !exp_d[3]});
    check_vec("t3_d_rdata", d_rdata, 64'h55);
    mem_rvalid = 1'b0;

    // 4: load whose data never returns
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    settle();
    check_vec("t4_d_gnt", {63'd0, d_gnt}, 64'd1);
    step(); d_req = 1'b0;          // ISSUE, accepted
    step();                        // entered WAIT
    for (int k = 0; k < 15; k++) step();
    settle();
    check_vec("t4_no_err_early", {62'd0, err, d_done}, 64'd0);
    step();
    if_req = 1'b1; if_addr = 64'h44;
    settle();
    check_vec("t4_err", {62'd0, err, d_done}, 64'd3);
    check_vec("t4_rdata_zero", d_rdata, 64'd0);
    check_vec("t4_next_gnt", {63'd0, if_gnt}, 64'd1);
    step(); if_req = 1'b0; settle();
    check_vec("t4_err_pulse", {63'd0, err}, 64'd0);
    step(); mem_rvalid = 1'b1; mem_rdata = 64'h66;
    step(); mem_rvalid = 1'b0; settle();
    check_vec("t4_fetch_after", if_rdata, 64'h66);

    // 5: restart while waiting for read data
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400;
    step(); d_req = 1'b0;
    step(); settle();
    check_vec("t5_in_wait", {63'd0, mem_req}, 64'd0);
    step(); restart_cpu = 1'b1;
    step(); restart_cpu = 1'b0; settle();
    check_vec("t5_mem_req", {63'd0, mem_req}, 64'd0);
    check_vec("t5_no_pulse_a", {61'd0, if_rvalid, d_done, err}, 64'd0);
    step(); step(); mem_rvalid = 1'b1; mem_rdata = 64'h77;
    step(); mem_rvalid = 1'b0; settle();
    check_vec("t5_no_pulse_b", {61'd0, if_rvalid, d_done, err}, 64'd0);
    check_vec("t5_rdata_clr", d_rdata, 64'd0);
    d_req = 1'b1; d_addr = 64'h500;
    settle();
    check_vec("t5_idle_gnt", {63'd0, d_gnt}, 64'd1);

    // 6: load completion and a new fetch grant in the same cycle
    step(); d_req = 1'b0;
    step(); mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    step(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 64'h88;
    settle();
    check_vec("t6_done_and_gnt", {62'd0, d_done, if_gnt}, 64'd3);
    check_vec("t6_d_rdata", d_rdata, 64'h1234);
    step(); if_req = 1'b0; settle();
    check_vec("t6_mem_addr", mem_addr, 64'h88);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
